// File: rtl/clock_reset_gen.sv
// Board clock/reset front end: conditions the raw push-button reset into a
// clean synchronous reset, then derives a divided fabric clock, a rising-edge
// strobe and a sticky lock flag from the board clock.
module clock_reset_gen #(
  parameter int unsigned STAGES      = 4,
  parameter int unsigned DIV         = 4,
  parameter int unsigned LOCK_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst,
  output logic clk_out,
  output logic clk_rise,
  output logic locked
);

  localparam int unsigned HalfDiv = DIV / 2;
  localparam int unsigned DivW    = (HalfDiv > 1) ? $clog2(HalfDiv) : 1;
  localparam int unsigned LockW   = (LOCK_CYCLES > 0) ? $clog2(LOCK_CYCLES + 1) : 1;

  localparam logic [DivW-1:0]  DivMax  = DivW'(HalfDiv - 1);
  localparam logic [LockW-1:0] LockMax = LockW'(LOCK_CYCLES - 1);

  // Elaboration-time parameter sanity.
  if (STAGES < 2) begin : g_bad_stages
    $error("clock_reset_gen: STAGES must be at least 2");
  end
  if ((DIV < 2) || ((DIV % 2) != 0)) begin : g_bad_div
    $error("clock_reset_gen: DIV must be even and at least 2");
  end
  if (LOCK_CYCLES < 1) begin : g_bad_lock
    $error("clock_reset_gen: LOCK_CYCLES must be at least 1");
  end

  logic [STAGES-1:0] sync_q;
  logic [DivW-1:0]   div_cnt;
  logic [LockW-1:0]  lock_cnt;

  // Reset synchronizer: async set to all ones, shift zeros in once released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], 1'b0};
    end
  end

  assign rst = sync_q[STAGES-1];

  // Divider, rise strobe and lock counter; held clear while rst is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      lock_cnt <= '0;
      clk_out  <= 1'b0;
      clk_rise <= 1'b0;
      locked   <= 1'b0;
    end else if (rst) begin
      div_cnt  <= '0;
      lock_cnt <= '0;
      clk_out  <= 1'b0;
      clk_rise <= 1'b0;
      locked   <= 1'b0;
    end else begin
      if (div_cnt == DivMax) begin
        div_cnt  <= '0;
        clk_out  <= ~clk_out;
        // Strobe only when the toggle takes clk_out from 0 to 1.
        clk_rise <= ~clk_out;
      end else begin
        div_cnt  <= div_cnt + DivW'(1);
        clk_rise <= 1'b0;
      end
      // Counter stops once locked, so it never wraps.
      if (!locked) begin
        lock_cnt <= lock_cnt + LockW'(1);
        if (lock_cnt == LockMax) begin
          locked <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_reset_gen.sv
// Directed bench for clock_reset_gen: a default-style instance (STAGES=4,
// DIV=4, LOCK_CYCLES=16) and a minimal one (STAGES=2, DIV=2) sharing rst_n.
module tb_clock_reset_gen;

  logic clk;
  logic rst_n;
  logic a_rst, a_clk_out, a_clk_rise, a_locked;
  logic b_rst, b_clk_out, b_clk_rise, b_locked;

  int checks = 0;
  int errors = 0;

  clock_reset_gen #(
    .STAGES     (4),
    .DIV        (4),
    .LOCK_CYCLES(16)
  ) dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .rst     (a_rst),
    .clk_out (a_clk_out),
    .clk_rise(a_clk_rise),
    .locked  (a_locked)
  );

  clock_reset_gen #(
    .STAGES     (2),
    .DIV        (2),
    .LOCK_CYCLES(16)
  ) dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .rst     (b_rst),
    .clk_out (b_clk_out),
    .clk_rise(b_clk_rise),
    .locked  (b_locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst_n;
    logic a_rst, a_out, a_rise, a_lock;
    logic b_rst, b_out, b_rise, b_lock;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input int idx, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s step %0d: got %b want %b", name, idx, got, want);
    end
  endtask

  task automatic check_all_reset(input int idx);
    check("a_rst_hold", idx, a_rst, 1'b1);
    check("a_clk_out_hold", idx, a_clk_out, 1'b0);
    check("a_clk_rise_hold", idx, a_clk_rise, 1'b0);
    check("a_locked_hold", idx, a_locked, 1'b0);
    check("b_rst_hold", idx, b_rst, 1'b1);
    check("b_clk_out_hold", idx, b_clk_out, 1'b0);
    check("b_clk_rise_hold", idx, b_clk_rise, 1'b0);
    check("b_locked_hold", idx, b_locked, 1'b0);
  endtask

  // Step through the release sequence: entry i is sampled after edge i+1.
  task automatic run_table();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      rst_n = vecs[i].rst_n;
      #1;
      check("a_rst", i + 1, a_rst, vecs[i].a_rst);
      check("a_clk_out", i + 1, a_clk_out, vecs[i].a_out);
      check("a_clk_rise", i + 1, a_clk_rise, vecs[i].a_rise);
      check("a_locked", i + 1, a_locked, vecs[i].a_lock);
      check("b_rst", i + 1, b_rst, vecs[i].b_rst);
      check("b_clk_out", i + 1, b_clk_out, vecs[i].b_out);
      check("b_clk_rise", i + 1, b_clk_rise, vecs[i].b_rise);
      check("b_locked", i + 1, b_locked, vecs[i].b_lock);
    end
  endtask

  initial begin
    // Edge n after release. A: rst falls after n=4, E1 is n=5, locked after E16 (n=20).
    // B: rst falls after n=2, E1 is n=3, toggles every edge, locked after n=18.
    //            rst_n  a_rst out  rise lock   b_rst out  rise lock
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[18] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    // Power-on: drive a real falling edge on rst_n before the first clk edge.
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_reset(0);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      check_all_reset(i);
    end

    // Release mid-period, then walk the deassert / divide / lock sequence.
    @(negedge clk);
    rst_n = 1'b1;
    run_table();

    // Lock is sticky; the fast divider keeps toggling every edge.
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      check("a_locked_sticky", i, a_locked, 1'b1);
      check("b_locked_sticky", i, b_locked, 1'b1);
      check("b_rise_tracks_out", i, b_clk_rise, b_clk_out);
    end

    // Short asynchronous pulse between edges while locked.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_reset(100);
    #1;
    rst_n = 1'b1;
    run_table();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
